grasspopper_stream_if: RTL
==========================

// Module: grasspopper_stream_if
// PURPOSE
// - Byte-stream front/back end for the grasspopper encoder pipeline.
// - Packs an 8-bit input stream into BLOCK_BYTES-byte blocks and issues each block into encoder data_i.
// - Tracks the block through the stall-free pipeline with a valid delay line.
// - Captures encoder data_o into an output FIFO; a credit scheme guarantees no result is ever dropped.
// PARAMETERS
// BLOCK_BYTES  32  bytes per block (8*BLOCK_BYTES = 256 = encoder bus width)
// PIPE_LAT     9   cycles from enc_valid_o high to enc_data_i holding that block's result
// OUT_DEPTH    4   output FIFO depth in blocks (>=1)
// PORTS
// clk          in   1    clock
// rst          in   1    reset: synchronous, active-high
// in_byte_i    in   8    input byte
// in_valid_i   in   1    in_byte_i valid
// in_last_i    in   1    qualified by in_valid_i; this byte ends the block, rest zero-padded
// in_ready_o   out  1    block accepts a byte this cycle
// enc_data_o   out  256  packed block to encoder data_i
// enc_valid_o  out  1    one-cycle issue strobe for enc_data_o
// enc_data_i   in   256  encoder data_o
// out_data_o   out  256  FIFO head (encoded block)
// out_valid_o  out  1    FIFO non-empty
// out_ready_i  in   1    consumer takes head
// inflight_o   out  clog2(OUT_DEPTH+1)  blocks issued but not yet captured
// BEHAVIOUR
// Reset
// - All regs cleared while rst is high: cnt, buffer, FSM=FILL, delay line, FIFO, inflight.
// - During the rst cycle every output reads 0, including in_ready_o.
// - Reset mid-operation discards partial block, in-flight blocks and FIFO contents.
// FSM FILL
// - in_ready_o=1; a byte is accepted when in_valid_i&&in_ready_o.
// - Byte k (0-based, k=cnt) goes to buf[255-8k -: 8]; the first byte lands in the MSBs.
// - Accepting with cnt==BLOCK_BYTES-1, or with in_last_i=1, moves the FSM to FULL.
// - Bytes not written stay 0, because buf is cleared on issue.
// FSM FULL
// - in_ready_o=0.
// - Issue when occ < OUT_DEPTH, where occ = fifo_count + inflight, both as registered at cycle start.
// - Issue cycle: enc_valid_o=1, enc_data_o=buf. Next edge: buf<=0, cnt<=0, FSM<=FILL, inflight+1.
// - No issue: stay in FULL; enc_valid_o stays 0.
// - enc_data_o always drives buf; consumers must only sample it when enc_valid_o=1.
// Delay line and capture
// - PIPE_LAT-bit shift register fed by enc_valid_o.
// - If issue happens in cycle c, enc_data_i is pushed into the FIFO at the end of cycle c+PIPE_LAT.
// - out_valid_o rises in cycle c+PIPE_LAT+1 when the FIFO was empty.
// - Capture decrements inflight; issue and capture in the same cycle leave inflight unchanged.
// - The credit rule guarantees the FIFO is never full at capture; overflow is an assertion failure.
// Output FIFO
// - First-word fall-through: out_data_o=head when out_valid_o=1, else 0.
// - Pop on out_valid_o&&out_ready_i.
// - Push and pop in the same cycle: count unchanged, order preserved.
// - A pop in the same cycle as the credit check does not free credit until the next cycle.
// Throughput and latency
// - Max 1 block per BLOCK_BYTES+1 cycles (one fill per byte, plus one issue cycle).
// - No pipeline stall; the credit scheme is the only backpressure path to the input.
// Width rules
// - cnt is clog2(BLOCK_BYTES) bits. occ compare uses clog2(OUT_DEPTH+1)+1 bits; no wrap.
// TESTING
// - T1 single block: bytes 0x00..0x1F, last on 0x1F.
//   - enc_valid_o 1 cycle later with enc_data_o=256'h0001..1F.
//   - Encoder model output appears on out_data_o exactly PIPE_LAT+1 cycles after issue.
// - T2 short block: 3 bytes AA,BB,CC with last on CC.
//   - enc_data_o = {8'hAA,8'hBB,8'hCC,232'h0}; the next block starts at cnt=0.
// - T3 backpressure: out_ready_i=0, feed 6 blocks.
//   - Exactly 4 issues; the 5th block is held in FULL with in_ready_o=0; inflight_o+count never >4.
//   - Release out_ready_i: all 6 blocks emerge in order, none lost.
// - T4 simultaneous events: time an issue to coincide with a capture and a pop.
//   - inflight_o is unchanged and the FIFO count is correct; no overflow assertion fires.
// - T5 reset mid-op: assert rst with 2 blocks in flight and 1 in the FIFO.
//   - Next cycle all outputs are 0; later stale captures are ignored; in_ready_o=1 after rst falls.
// - T6 random stream: 1000 bytes with random valid/ready/last.
//   - Scoreboard of model(encode(packed)) matches out_data_o sequence.

Source files
------------

// File: rtl/grasspopper_stream_if.sv
// Byte-stream packer and result collector around the stall-free grasspopper encoder.
// Bytes are packed MSB-first into one block; results are captured into a credit-protected FWFT FIFO.
module grasspopper_stream_if #(
   parameter int BLOCK_BYTES = 32,
   parameter int PIPE_LAT    = 9,
   parameter int OUT_DEPTH   = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [7:0]                         in_byte_i,
   input  logic                               in_valid_i,
   input  logic                               in_last_i,
   output logic                               in_ready_o,
   output logic [8*BLOCK_BYTES-1:0]           enc_data_o,
   output logic                               enc_valid_o,
   input  logic [8*BLOCK_BYTES-1:0]           enc_data_i,
   output logic [8*BLOCK_BYTES-1:0]           out_data_o,
   output logic                               out_valid_o,
   input  logic                               out_ready_i,
   output logic [$clog2(OUT_DEPTH+1)-1:0]     inflight_o
);
   localparam int DW    = 8 * BLOCK_BYTES;
   localparam int CNT_W = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
   localparam int CRW   = $clog2(OUT_DEPTH + 1);
   localparam int OCC_W = CRW + 1;
   localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

   typedef enum logic {FILL, FULL} state_t;

   state_t               state_reg, state_next;
   logic [CNT_W-1:0]     cnt_reg;
   logic [DW-1:0]        blk_reg;
   logic [PIPE_LAT-1:0]  dly_reg;
   logic [CRW-1:0]       inflight_reg;
   logic [CRW-1:0]       count_reg;
   logic [PTR_W-1:0]     rd_ptr_reg, wr_ptr_reg;
   logic [DW-1:0]        fifo_mem [OUT_DEPTH];

   logic                 accept, last_byte, credit, issue, fill_ready;
   logic                 capture, pop;
   logic [OCC_W-1:0]     occ;
   logic [BLOCK_BYTES-1:0] byte_sel;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Credit counts both captured results and blocks still inside the encoder.
   assign occ       = OCC_W'(count_reg) + OCC_W'(inflight_reg);
   assign credit    = occ < OCC_W'(OUT_DEPTH);
   assign accept    = in_valid_i && fill_ready;
   assign last_byte = in_last_i || (cnt_reg == CNT_W'(BLOCK_BYTES - 1));
   assign capture   = dly_reg[PIPE_LAT-1];
   assign pop       = out_valid_o && out_ready_i;

   for (genvar gi = 0; gi < BLOCK_BYTES; gi++) begin : g_sel
      assign byte_sel[gi] = accept && (cnt_reg == CNT_W'(gi));
   end

   always_ff @(posedge clk) begin
      if (rst) state_reg <= FILL;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         FILL:    if (accept && last_byte) state_next = FULL;
         FULL:    if (credit) state_next = FILL;
         default: state_next = FILL;
      endcase
   end

   always_comb begin
      fill_ready = 1'b0;
      issue      = 1'b0;
      if (!rst) begin
         fill_ready = (state_reg == FILL);
         issue      = (state_reg == FULL) && credit;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg      <= '0;
         blk_reg      <= '0;
         dly_reg      <= '0;
         inflight_reg <= '0;
         count_reg    <= '0;
         rd_ptr_reg   <= '0;
         wr_ptr_reg   <= '0;
      end else begin
         if (issue) begin
            blk_reg <= '0;
            cnt_reg <= '0;
         end else if (accept) begin
            for (int i = 0; i < BLOCK_BYTES; i++)
               if (byte_sel[i]) blk_reg[DW-8-8*i +: 8] <= in_byte_i;
            cnt_reg <= cnt_reg + CNT_W'(1);
         end
         dly_reg <= (dly_reg << 1) | PIPE_LAT'(issue);
         if (issue && !capture)      inflight_reg <= inflight_reg + CRW'(1);
         else if (capture && !issue) inflight_reg <= inflight_reg - CRW'(1);
         if (capture) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         if (pop)     rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         if (capture && !pop)      count_reg <= count_reg + CRW'(1);
         else if (pop && !capture) count_reg <= count_reg - CRW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && capture) fifo_mem[wr_ptr_reg] <= enc_data_i;
   end

   assign in_ready_o  = fill_ready;
   assign enc_valid_o = issue;
   assign enc_data_o  = rst ? '0 : blk_reg;
   assign out_valid_o = !rst && (count_reg != '0);
   assign out_data_o  = out_valid_o ? fifo_mem[rd_ptr_reg] : '0;
   assign inflight_o  = rst ? '0 : inflight_reg;

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(capture && count_reg == CRW'(OUT_DEPTH)));

endmodule
